// File: rtl/reduce_pkg.sv
// Shared definitions for the reduce ingress path: flit field positions,
// source-select codes and the ingress arbiter state encoding.
package reduce_pkg;

  localparam int unsigned FLIT_W            = 82;
  localparam int unsigned CHILD_W           = 3;
  localparam int unsigned FLIT_CHILD_W      = FLIT_W + CHILD_W;
  localparam int unsigned VALID_BIT_POS     = 81;
  localparam int unsigned REDUCTION_BIT_POS = 80;

  localparam int unsigned           SEL_W     = 3;
  localparam logic [SEL_W-1:0]      SEL_LOCAL = 3'd6;
  localparam logic [SEL_W-1:0]      SEL_NONE  = 3'd7;

  typedef enum logic {
    LOCAL_PREF = 1'b0,
    PORT_TURN  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin requester picker: searches upward from ptr_i (wrapping) and
// returns the first requester as a one-hot grant plus its index.
module rr_arbiter #(
  parameter int unsigned N  = 6,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  int unsigned j;

  // First requester at or after the pointer, wrapping past N-1 to 0.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    j       = 0;
    for (int unsigned i = 0; i < N; i++) begin
      j = (32'(ptr_i) + i) % N;
      if (!valid_o && req_i[IW'(j)]) begin
        grant_o[IW'(j)] = 1'b1;
        idx_o           = IW'(j);
        valid_o         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reduce_ingress_arbiter.sv
// Schedules reduction flits from six port FIFOs and the local injector into
// the single reduce FIFO, gated by downstream credits, with a burst limit so
// local injection cannot starve the network ports.
module reduce_ingress_arbiter
  import reduce_pkg::*;
#(
  parameter int unsigned NUM_PORTS       = 6,
  parameter int unsigned DATA_W          = 85,
  parameter int unsigned VALID_POS       = 81,
  parameter int unsigned DOWN_DEPTH      = 16,
  parameter int unsigned LOCAL_MAX_BURST = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_PORTS-1:0]              port_req,
  input  logic [NUM_PORTS*DATA_W-1:0]       port_data,
  output logic [NUM_PORTS-1:0]              port_grant,
  input  logic [DATA_W-1:0]                 local_in,
  output logic                              local_ready,
  input  logic                              down_consume,
  output logic [DATA_W-1:0]                 out_flit,
  output logic                              out_valid,
  output logic [SEL_W-1:0]                  out_sel,
  output logic [$clog2(DOWN_DEPTH+1)-1:0]   credits
);

  localparam int unsigned PW = $clog2(NUM_PORTS);
  localparam int unsigned BW = $clog2(LOCAL_MAX_BURST + 1);
  localparam int unsigned CW = $clog2(DOWN_DEPTH + 1);

  arb_state_e          state_q, state_d;
  logic [BW-1:0]       burst_q, burst_d;
  logic [PW-1:0]       rr_q, rr_d;
  logic [CW-1:0]       credits_q, credits_d;
  logic                out_valid_q;
  logic [DATA_W-1:0]   out_flit_q;
  logic [SEL_W-1:0]    out_sel_q;

  logic [NUM_PORTS-1:0] rr_grant;
  logic [PW-1:0]        rr_idx;
  logic                 rr_valid;
  logic                 local_req;
  logic                 any_grant;
  logic                 consume_ok;
  logic [SEL_W-1:0]     sel_c;
  logic [DATA_W-1:0]    data_c;

  assign local_req = local_in[VALID_POS];

  rr_arbiter #(
    .N  (NUM_PORTS),
    .IW (PW)
  ) u_rr (
    .req_i   (port_req),
    .ptr_i   (rr_q),
    .grant_o (rr_grant),
    .idx_o   (rr_idx),
    .valid_o (rr_valid)
  );

  // Grant decision: local preference with burst cap, port turn after a full burst.
  always_comb begin
    state_d     = state_q;
    burst_d     = burst_q;
    rr_d        = rr_q;
    port_grant  = '0;
    local_ready = 1'b0;
    sel_c       = SEL_NONE;
    if (!rst && state_q == PORT_TURN && !rr_valid) begin
      state_d = LOCAL_PREF;
      burst_d = '0;
    end
    if (!rst && credits_q != '0) begin
      if (state_q == PORT_TURN && rr_valid) begin
        port_grant = rr_grant;
        sel_c      = SEL_W'(rr_idx);
        rr_d       = (rr_idx == PW'(NUM_PORTS - 1)) ? '0 : rr_idx + PW'(1);
        burst_d    = '0;
        state_d    = LOCAL_PREF;
      end else if (local_req) begin
        local_ready = 1'b1;
        sel_c       = SEL_LOCAL;
        state_d     = LOCAL_PREF;
        if (|port_req) begin
          burst_d = burst_q + BW'(1);
          if (burst_d == BW'(LOCAL_MAX_BURST)) state_d = PORT_TURN;
        end else begin
          burst_d = '0;
        end
      end else if (rr_valid) begin
        port_grant = rr_grant;
        sel_c      = SEL_W'(rr_idx);
        rr_d       = (rr_idx == PW'(NUM_PORTS - 1)) ? '0 : rr_idx + PW'(1);
        burst_d    = '0;
        state_d    = LOCAL_PREF;
      end
    end
  end

  // Data mux for the granted source.
  always_comb begin
    data_c = local_in;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (port_grant[i]) data_c = port_data[i*DATA_W +: DATA_W];
    end
  end

  assign any_grant  = (|port_grant) | local_ready;
  // A consume with the FIFO already empty is dropped so credits never exceed depth.
  assign consume_ok = down_consume && ((credits_q != CW'(DOWN_DEPTH)) || any_grant);

  // Credit bookkeeping: grant spends one, consume returns one.
  always_comb begin
    credits_d = credits_q;
    if (any_grant && !consume_ok)      credits_d = credits_q - CW'(1);
    else if (!any_grant && consume_ok) credits_d = credits_q + CW'(1);
  end

  // State, counters and the single output register stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOCAL_PREF;
      burst_q     <= '0;
      rr_q        <= '0;
      credits_q   <= CW'(DOWN_DEPTH);
      out_valid_q <= 1'b0;
      out_flit_q  <= '0;
      out_sel_q   <= SEL_NONE;
    end else begin
      state_q     <= state_d;
      burst_q     <= burst_d;
      rr_q        <= rr_d;
      credits_q   <= credits_d;
      out_valid_q <= any_grant;
      out_sel_q   <= sel_c;
      if (any_grant) out_flit_q <= data_c;
    end
  end

  assign out_valid = out_valid_q;
  assign out_flit  = out_flit_q;
  assign out_sel   = out_sel_q;
  assign credits   = credits_q;

  // Downstream must not report a consume while the reduce FIFO is empty.
  a_no_credit_overflow: assert property (@(posedge clk) disable iff (rst)
    !(down_consume && !any_grant && credits_q == CW'(DOWN_DEPTH)));

endmodule

// File: tb/tb_reduce_ingress_arbiter.sv
// Self-checking bench for reduce_ingress_arbiter: table-driven grant sequences
// plus hand-written credit and reset sequences, registered outputs scoreboarded.
module tb_reduce_ingress_arbiter;

  localparam int NP    = 6;
  localparam int DW    = 85;
  localparam int VP    = 81;
  localparam int DEPTH = 16;
  localparam logic [2:0] S_LOC  = 3'd6;
  localparam logic [2:0] S_NONE = 3'd7;

  logic              clk = 1'b0;
  logic              rst;
  logic [NP-1:0]     port_req;
  logic [NP*DW-1:0]  port_data;
  logic [NP-1:0]     port_grant;
  logic [DW-1:0]     local_in;
  logic              local_ready;
  logic              down_consume;
  logic [DW-1:0]     out_flit;
  logic              out_valid;
  logic [2:0]        out_sel;
  logic [4:0]        credits;

  always #5 clk = ~clk;

  reduce_ingress_arbiter #(
    .NUM_PORTS(NP), .DATA_W(DW), .VALID_POS(VP), .DOWN_DEPTH(DEPTH), .LOCAL_MAX_BURST(4)
  ) dut (
    .clk(clk), .rst(rst), .port_req(port_req), .port_data(port_data),
    .port_grant(port_grant), .local_in(local_in), .local_ready(local_ready),
    .down_consume(down_consume), .out_flit(out_flit), .out_valid(out_valid),
    .out_sel(out_sel), .credits(credits)
  );

  typedef struct {
    logic [NP-1:0] req;
    logic          lv;
    logic          cons;
    logic [2:0]    sel;
  } vec_t;

  typedef struct {
    logic          vld;
    logic [2:0]    sel;
    logic [DW-1:0] flit;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_cred;
  int   tag = 0;
  int   rr_m;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void add(input logic [NP-1:0] req, input logic lv, input logic cons,
                              input logic [2:0] sel);
    vec_t v;
    v.req = req; v.lv = lv; v.cons = cons; v.sel = sel;
    tbl.push_back(v);
  endfunction

  // Compare the registered outputs against the oldest scoreboard entry.
  task automatic check_registered();
    exp_t e;
    if (sb.size() > 0) e = sb.pop_front();
    else begin
      e.vld = 1'b0; e.sel = S_NONE; e.flit = '0;
    end
    chk("out_valid", 128'(out_valid), 128'(e.vld));
    chk("out_sel",   128'(out_sel),   128'(e.sel));
    if (e.vld) chk("out_flit", 128'(out_flit), 128'(e.flit));
    chk("credits", 128'(credits), 128'(exp_cred));
  endtask

  // One cycle: check last cycle's result, drive new inputs, check the grant.
  task automatic step(input logic [NP-1:0] req, input logic lv, input logic cons,
                      input logic [2:0] sel);
    exp_t          e;
    logic          c_eff;
    logic [NP-1:0] eg;
    @(posedge clk); #1;
    check_registered();
    c_eff = cons && !(exp_cred == DEPTH && sel == S_NONE);
    tag++;
    for (int i = 0; i < NP; i++)
      port_data[i*DW +: DW] = (DW'(tag) << 8) | DW'(i) | (DW'(1) << VP);
    local_in     = (DW'(tag) << 8) | DW'(8'hAA);
    local_in[VP] = lv;
    port_req     = req;
    down_consume = c_eff;
    #1;
    eg = (sel < 3'd6) ? (NP'(1) << sel) : '0;
    chk("port_grant",  128'(port_grant),  128'(eg));
    chk("local_ready", 128'(local_ready), 128'(sel == S_LOC));
    e.vld  = (sel != S_NONE);
    e.sel  = sel;
    e.flit = (sel == S_LOC) ? local_in : ((sel < 3'd6) ? port_data[int'(sel)*DW +: DW] : '0);
    sb.push_back(e);
    exp_cred = exp_cred - (e.vld ? 1 : 0) + (c_eff ? 1 : 0);
  endtask

  // Assert reset with every source requesting and confirm nothing leaks out.
  task automatic do_reset(input int cycles);
    @(posedge clk); #1;
    check_registered();
    rst          = 1'b1;
    port_req     = '1;
    local_in[VP] = 1'b1;
    down_consume = 1'b0;
    #1;
    chk("rst_port_grant",  128'(port_grant),  128'(0));
    chk("rst_local_ready", 128'(local_ready), 128'(0));
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      chk("rst_out_valid",   128'(out_valid),   128'(0));
      chk("rst_out_sel",     128'(out_sel),     128'(S_NONE));
      chk("rst_credits",     128'(credits),     128'(DEPTH));
      chk("rst_port_grant",  128'(port_grant),  128'(0));
      chk("rst_local_ready", 128'(local_ready), 128'(0));
    end
    rst          = 1'b0;
    port_req     = '0;
    local_in     = '0;
    sb.delete();
    exp_cred     = DEPTH;
  endtask

  initial begin
    rst = 1'b1; port_req = '0; port_data = '0; local_in = '0; down_consume = 1'b0;
    exp_cred = DEPTH;
    @(posedge clk); #1;

    // Reset with all requests held high.
    do_reset(3);

    // Round-robin across all ports.
    for (int k = 0; k < 8; k++) add('1, 1'b0, 1'b1, 3'(k % 6));
    // Local bursts of four interleaved with the requesting port.
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) add(6'h04, 1'b1, 1'b1, S_LOC);
      add(6'h04, 1'b1, 1'b1, 3'd2);
    end
    // Port turn with no port requests lets local through and clears the burst.
    for (int k = 0; k < 4; k++) add(6'h04, 1'b1, 1'b1, S_LOC);
    for (int k = 0; k < 4; k++) add(6'h00, 1'b1, 1'b1, S_LOC);
    for (int k = 0; k < 4; k++) add(6'h04, 1'b1, 1'b1, S_LOC);
    add(6'h04, 1'b1, 1'b1, 3'd2);
    add(6'h00, 1'b0, 1'b0, S_NONE);
    // Round-robin wrap from pointer 3 over sparse requests.
    add(6'h21, 1'b0, 1'b1, 3'd5);
    add(6'h21, 1'b0, 1'b1, 3'd0);

    foreach (tbl[i]) step(tbl[i].req, tbl[i].lv, tbl[i].cons, tbl[i].sel);

    // Credits exhaust after sixteen grants, then stall.
    rr_m = 1;
    for (int k = 0; k < 16; k++) begin
      step('1, 1'b0, 1'b0, 3'(rr_m));
      rr_m = (rr_m + 1) % 6;
    end
    for (int k = 0; k < 3; k++) step('1, 1'b0, 1'b0, S_NONE);
    // Consume at zero credits: no grant this cycle, exactly one next cycle.
    step('1, 1'b0, 1'b1, S_NONE);
    step('1, 1'b0, 1'b0, 3'(rr_m));
    rr_m = (rr_m + 1) % 6;
    step('1, 1'b0, 1'b0, S_NONE);

    // Refill to five, then grant and consume together.
    for (int k = 0; k < 5; k++) step('0, 1'b0, 1'b1, S_NONE);
    step('1, 1'b0, 1'b1, 3'(rr_m));

    // Build credits=9 with a pending output, then reset mid-operation.
    for (int k = 0; k < 5; k++) step('0, 1'b0, 1'b1, S_NONE);
    step(6'h04, 1'b0, 1'b0, 3'd2);
    do_reset(1);
    // Pointer back at port 0 after reset.
    step('1, 1'b0, 1'b1, 3'd0);
    step('0, 1'b0, 1'b0, S_NONE);
    @(posedge clk); #1;
    check_registered();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
